// File: rtl/chacha_block_core.sv
// Iterative ChaCha block function: one column or diagonal round per clock, then the
// feed-forward addition of the saved input state to produce a 512-bit keystream block.
module chacha_block_core #(
    parameter int ROUNDS = 20
) (
    input  logic         clk_i,
    input  logic         rst_ni,
    input  logic         start_i,
    input  logic [511:0] BLOCK_i,
    output logic         ready_o,
    output logic         valid_o,
    output logic [511:0] BLOCK_o
);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        ROUND = 2'd1,
        FINAL = 2'd2
    } state_t;

    localparam logic [4:0] LAST_ROUND = 5'(ROUNDS);

    state_t       state_q;
    state_t       state_d;
    logic [511:0] work_q;
    logic [511:0] saved_q;
    logic [4:0]   rnd_q;
    logic [511:0] round_out;
    logic [511:0] final_sum;

    function automatic logic [31:0] rotl32(input logic [31:0] v, input int n);
        return (v << n) | (v >> (32 - n));
    endfunction

    // Returns {a, b, c, d} after one quarter round.
    function automatic logic [127:0] quarter_round(input logic [31:0] a_in, input logic [31:0] b_in,
                                                   input logic [31:0] c_in, input logic [31:0] d_in);
        logic [31:0] a, b, c, d;
        a = a_in; b = b_in; c = c_in; d = d_in;
        a = a + b; d = rotl32(d ^ a, 16);
        c = c + d; b = rotl32(b ^ c, 12);
        a = a + b; d = rotl32(d ^ a, 8);
        c = c + d; b = rotl32(b ^ c, 7);
        return {a, b, c, d};
    endfunction

    function automatic logic [511:0] column_round(input logic [511:0] w);
        logic [511:0] o;
        logic [127:0] q;
        o = '0;
        for (int c = 0; c < 4; c++) begin
            q = quarter_round(w[32*c +: 32], w[32*(4+c) +: 32], w[32*(8+c) +: 32], w[32*(12+c) +: 32]);
            o[32*c      +: 32] = q[127:96];
            o[32*(4+c)  +: 32] = q[95:64];
            o[32*(8+c)  +: 32] = q[63:32];
            o[32*(12+c) +: 32] = q[31:0];
        end
        return o;
    endfunction

    // Row-rotation stage: forward shifts row r left by r words, inverse undoes it,
    // so diagonals line up as columns for the shared column quarter rounds.
    function automatic logic [511:0] row_rotate(input logic [511:0] w, input logic inverse);
        logic [511:0] o;
        int src;
        o = '0;
        for (int r = 0; r < 4; r++) begin
            for (int c = 0; c < 4; c++) begin
                src = inverse ? ((c - r + 4) % 4) : ((c + r) % 4);
                o[32*(4*r+c) +: 32] = w[32*(4*r+src) +: 32];
            end
        end
        return o;
    endfunction

    always_comb begin
        round_out = '0;
        if (rnd_q[0]) begin
            round_out = column_round(work_q);
        end else begin
            round_out = row_rotate(column_round(row_rotate(work_q, 1'b0)), 1'b1);
        end
    end

    always_comb begin
        final_sum = '0;
        for (int k = 0; k < 16; k++) begin
            final_sum[32*k +: 32] = work_q[32*k +: 32] + saved_q[32*k +: 32];
        end
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE:    if (start_i) state_d = ROUND;
            ROUND:   if (rnd_q == LAST_ROUND) state_d = FINAL;
            FINAL:   state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    assign ready_o = (state_q == IDLE);

    // Datapath registers; start_i outside IDLE is dropped without queuing.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            work_q  <= '0;
            saved_q <= '0;
            rnd_q   <= '0;
            BLOCK_o <= '0;
            valid_o <= 1'b0;
        end else begin
            valid_o <= 1'b0;
            case (state_q)
                IDLE: begin
                    if (start_i) begin
                        work_q  <= BLOCK_i;
                        saved_q <= BLOCK_i;
                        rnd_q   <= 5'd1;
                    end
                end
                ROUND: begin
                    work_q <= round_out;
                    if (rnd_q != LAST_ROUND) rnd_q <= rnd_q + 5'd1;
                end
                FINAL: begin
                    BLOCK_o <= final_sum;
                    valid_o <= 1'b1;
                end
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_chacha_block_core.sv
// Self-checking bench for chacha_block_core: known vectors, a reference ChaCha model,
// busy/back-to-back sequencing and asynchronous reset abort.
module tb_chacha_block_core;

    logic         clk = 1'b0;
    logic         rst_n = 1'b0;
    logic         start20 = 1'b0;
    logic         start1 = 1'b0;
    logic [511:0] blk20 = '0;
    logic [511:0] blk1 = '0;
    logic         ready20, valid20, ready1, valid1;
    logic [511:0] out20, out1;

    int n_checks = 0;
    int n_fail = 0;

    always #5 clk = ~clk;

    chacha_block_core #(.ROUNDS(20)) dut20 (
        .clk_i(clk), .rst_ni(rst_n), .start_i(start20), .BLOCK_i(blk20),
        .ready_o(ready20), .valid_o(valid20), .BLOCK_o(out20)
    );

    chacha_block_core #(.ROUNDS(1)) dut1 (
        .clk_i(clk), .rst_ni(rst_n), .start_i(start1), .BLOCK_i(blk1),
        .ready_o(ready1), .valid_o(valid1), .BLOCK_o(out1)
    );

    typedef struct packed {
        logic         use20;
        logic [511:0] blk;
        logic [15:0]  idx;
        logic [127:0] val;
    } vec_t;

    function automatic logic [31:0] rotl(input logic [31:0] v, input int n);
        return (v << n) | (v >> (32 - n));
    endfunction

    // Reference: quarter rounds on the column / diagonal index sets, then feed-forward add.
    function automatic logic [511:0] ref_block(input logic [511:0] blk, input int rounds);
        logic [31:0] x [16];
        logic [31:0] a, b, c, d;
        int ib, ic, id;
        logic [511:0] o;
        for (int k = 0; k < 16; k++) x[k] = blk[32*k +: 32];
        for (int r = 1; r <= rounds; r++) begin
            for (int i = 0; i < 4; i++) begin
                if (r % 2 == 1) begin
                    ib = 4 + i; ic = 8 + i; id = 12 + i;
                end else begin
                    ib = 4 + (i + 1) % 4; ic = 8 + (i + 2) % 4; id = 12 + (i + 3) % 4;
                end
                a = x[i]; b = x[ib]; c = x[ic]; d = x[id];
                a = a + b; d = rotl(d ^ a, 16);
                c = c + d; b = rotl(b ^ c, 12);
                a = a + b; d = rotl(d ^ a, 8);
                c = c + d; b = rotl(b ^ c, 7);
                x[i] = a; x[ib] = b; x[ic] = c; x[id] = d;
            end
        end
        for (int k = 0; k < 16; k++) o[32*k +: 32] = x[k] + blk[32*k +: 32];
        return o;
    endfunction

    task automatic check_output(input string name, input logic [511:0] act, input logic [511:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("[TB] FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    function automatic logic [511:0] rand_block();
        logic [511:0] b;
        for (int k = 0; k < 16; k++) b[32*k +: 32] = $urandom;
        return b;
    endfunction

    // Issue one start on the selected instance and watch 60 cycles for completions.
    task automatic apply_stimulus(input logic use20, input logic [511:0] blk,
                                  output logic [511:0] res, output int lat, output int pulses);
        logic v, rdy;
        @(negedge clk);
        if (use20) begin start20 = 1'b1; blk20 = blk; end
        else begin start1 = 1'b1; blk1 = blk; end
        @(posedge clk);
        #1;
        start20 = 1'b0; start1 = 1'b0;
        lat = -1; pulses = 0; res = '0;
        for (int i = 1; i <= 60; i++) begin
            @(posedge clk);
            #1;
            v   = use20 ? valid20 : valid1;
            rdy = use20 ? ready20 : ready1;
            if (i == 1) check_output("busy_ready", 512'(rdy), 512'(0));
            if (v) begin
                pulses++;
                if (lat < 0) begin
                    lat = i;
                    res = use20 ? out20 : out1;
                    check_output("ready_at_valid", 512'(rdy), 512'(1));
                end
            end
        end
    endtask

    logic [511:0] chacha_in;
    logic [511:0] zero_blk;
    logic [511:0] qr_in;
    logic [511:0] res, res2, exp_blk;
    vec_t         vecs [3];
    int           lat, lat2, pulses, rounds;

    initial begin
        chacha_in = '0;
        chacha_in[32*0 +: 32] = 32'h61707865;
        chacha_in[32*1 +: 32] = 32'h3320646e;
        chacha_in[32*2 +: 32] = 32'h79622d32;
        chacha_in[32*3 +: 32] = 32'h6b206574;
        for (int k = 0; k < 8; k++) begin
            chacha_in[32*(4+k) +: 32] = {8'(4*k+3), 8'(4*k+2), 8'(4*k+1), 8'(4*k)};
        end
        chacha_in[32*12 +: 32] = 32'h00000001;
        chacha_in[32*13 +: 32] = 32'h09000000;
        chacha_in[32*14 +: 32] = 32'h4a000000;
        chacha_in[32*15 +: 32] = 32'h00000000;

        qr_in = '0;
        qr_in[32*0  +: 32] = 32'h11111111;
        qr_in[32*4  +: 32] = 32'h01020304;
        qr_in[32*8  +: 32] = 32'h9b8d6f43;
        qr_in[32*12 +: 32] = 32'h01234567;
        zero_blk = '0;

        vecs[0] = '{use20: 1'b0, blk: qr_in, idx: {4'd12, 4'd8, 4'd4, 4'd0},
                    val: {32'h59a50a22, 32'he10eb671, 32'hcc1efbd2, 32'hfb3ba405}};
        vecs[1] = '{use20: 1'b1, blk: chacha_in, idx: {4'd0, 4'd15, 4'd1, 4'd0},
                    val: {32'he4e7f110, 32'h4e3c50a2, 32'h15593bd1, 32'he4e7f110}};
        vecs[2] = '{use20: 1'b1, blk: zero_blk, idx: {4'd15, 4'd10, 4'd5, 4'd0},
                    val: {32'h0, 32'h0, 32'h0, 32'h0}};

        repeat (3) @(posedge clk);
        #1;
        check_output("reset_ready", 512'(ready20), 512'(1));
        check_output("reset_valid", 512'(valid20), 512'(0));
        check_output("reset_block", out20, '0);
        @(negedge clk);
        rst_n = 1'b1;

        for (int v = 0; v < 3; v++) begin
            rounds = vecs[v].use20 ? 20 : 1;
            apply_stimulus(vecs[v].use20, vecs[v].blk, res, lat, pulses);
            check_output($sformatf("vec%0d_latency", v), 512'(lat), 512'(rounds + 1));
            check_output($sformatf("vec%0d_pulses", v), 512'(pulses), 512'(1));
            for (int j = 0; j < 4; j++) begin
                check_output($sformatf("vec%0d_word%0d", v, vecs[v].idx[4*j +: 4]),
                             512'(res[32*vecs[v].idx[4*j +: 4] +: 32]), 512'(vecs[v].val[32*j +: 32]));
            end
            check_output($sformatf("vec%0d_model", v), res, ref_block(vecs[v].blk, rounds));
        end

        for (int t = 0; t < 8; t++) begin
            exp_blk = rand_block();
            rounds = (t % 2 == 0) ? 20 : 1;
            apply_stimulus(t % 2 == 0, exp_blk, res, lat, pulses);
            check_output($sformatf("rand%0d_latency", t), 512'(lat), 512'(rounds + 1));
            check_output($sformatf("rand%0d_block", t), res, ref_block(exp_blk, rounds));
        end

        // Starts while busy must be ignored.
        @(negedge clk);
        start20 = 1'b1; blk20 = chacha_in;
        @(posedge clk);
        #1;
        start20 = 1'b0;
        lat = -1; pulses = 0; res = '0;
        for (int i = 1; i <= 60; i++) begin
            @(posedge clk);
            #1;
            if (valid20) begin
                pulses++;
                if (lat < 0) begin lat = i; res = out20; end
            end
            start20 = (i == 2 || i == 9);
            blk20 = rand_block();
        end
        start20 = 1'b0;
        check_output("busy_pulses", 512'(pulses), 512'(1));
        check_output("busy_latency", 512'(lat), 512'(21));
        check_output("busy_result", res, ref_block(chacha_in, 20));

        // start held high across two jobs.
        exp_blk = rand_block();
        @(negedge clk);
        start20 = 1'b1; blk20 = chacha_in;
        @(posedge clk);
        #1;
        blk20 = exp_blk;
        lat = -1; lat2 = -1; pulses = 0; res2 = '0;
        for (int i = 1; i <= 60; i++) begin
            @(posedge clk);
            #1;
            if (valid20) begin
                pulses++;
                if (lat < 0) begin lat = i; res = out20; end
                else if (lat2 < 0) begin lat2 = i; res2 = out20; end
            end
            if (i == 22) start20 = 1'b0;
        end
        start20 = 1'b0;
        check_output("b2b_pulses", 512'(pulses), 512'(2));
        check_output("b2b_latency1", 512'(lat), 512'(21));
        check_output("b2b_latency2", 512'(lat2), 512'(43));
        check_output("b2b_result1", res, ref_block(chacha_in, 20));
        check_output("b2b_result2", res2, ref_block(exp_blk, 20));

        // Asynchronous reset in cycle 7 of a job aborts it silently.
        @(negedge clk);
        start20 = 1'b1; blk20 = chacha_in;
        @(posedge clk);
        #1;
        start20 = 1'b0;
        repeat (7) @(posedge clk);
        #2;
        rst_n = 1'b0;
        #1;
        check_output("abort_ready", 512'(ready20), 512'(1));
        check_output("abort_valid", 512'(valid20), 512'(0));
        check_output("abort_block", out20, '0);
        @(negedge clk);
        rst_n = 1'b1;
        pulses = 0;
        for (int i = 0; i < 40; i++) begin
            @(posedge clk);
            #1;
            if (valid20) pulses++;
        end
        check_output("abort_no_valid", 512'(pulses), 512'(0));
        check_output("abort_idle", 512'(ready20), 512'(1));

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
